// File: rtl/bmu_soft_pipe.sv
// Soft-decision branch metric unit, two-stage valid/ready pipeline.
// Optional erasure support: define BMU_ERASURE_EN.
module bmu_soft_pipe #(
    parameter  int K   = 3,
    parameter  int G0  = 7,
    parameter  int G1  = 5,
    parameter  int SW  = 3,
    parameter  int CW  = 16,
    localparam int BMW = SW + 1,
    localparam int NBR = 1 << K
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SW-1:0]      r0,
    input  logic [SW-1:0]      r1,
    input  logic               in_last,
    input  logic [1:0]         erase,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NBR*BMW-1:0] bm,
    output logic               out_last,
    output logic [CW-1:0]      sym_cnt
);

    localparam logic [SW-1:0] BMAX = '1;

    logic               r_init;
    logic               r_v1;
    logic               r_last1;
    logic [SW-1:0]      r_d0z;
    logic [SW-1:0]      r_d0o;
    logic [SW-1:0]      r_d1z;
    logic [SW-1:0]      r_d1o;
    logic               r_v2;
    logic               r_last2;
    logic [NBR*BMW-1:0] r_bm;
    logic [CW-1:0]      r_cnt;

    logic               w_ld1;
    logic               w_ld2;
    logic               w_acc;
    logic               w_load2;
    logic               w_xfer;
    logic [SW-1:0]      w_d0z;
    logic [SW-1:0]      w_d0o;
    logic [SW-1:0]      w_d1z;
    logic [SW-1:0]      w_d1o;
    logic [NBR*BMW-1:0] w_bm;

    // Handshake: a stage may load when it is empty or its successor moves.
    always_comb begin
        w_ld2    = !r_v2 || out_ready;
        w_ld1    = !r_v1 || w_ld2;
        in_ready = r_init && w_ld1 && !flush;
        w_acc    = in_valid && in_ready;
        w_load2  = w_ld2 && r_v1 && !flush;
        w_xfer   = r_v2 && out_ready && !flush;
    end

`ifdef BMU_ERASURE_EN
    // Per-bit distances to code bit 0 and 1; a punctured bit costs nothing.
    always_comb begin
        w_d0z = erase[0] ? '0 : r0;
        w_d0o = erase[0] ? '0 : BMAX - r0;
        w_d1z = erase[1] ? '0 : r1;
        w_d1o = erase[1] ? '0 : BMAX - r1;
    end
`else
    logic w_unused_erase;
    assign w_unused_erase = ^erase;

    // Per-bit distances to code bit 0 and 1.
    always_comb begin
        w_d0z = r0;
        w_d0o = BMAX - r0;
        w_d1z = r1;
        w_d1o = BMAX - r1;
    end
`endif

    // Branch b = {s, u}; code bits are fixed per branch at elaboration.
    for (genvar b = 0; b < NBR; b++) begin : g_br
        localparam int V  = ((b % 2) << (K - 1)) | (b / 2);
        localparam bit C0 = ^(G0 & V);
        localparam bit C1 = ^(G1 & V);
        assign w_bm[b*BMW +: BMW] =
            (C0 ? {1'b0, r_d0o} : {1'b0, r_d0z}) +
            (C1 ? {1'b0, r_d1o} : {1'b0, r_d1z});
    end

    // Hold in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init <= 1'b0;
        end else begin
            r_init <= 1'b1;
        end
    end

    // Stage 1: register both candidate distances per received bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_d0z   <= '0;
            r_d0o   <= '0;
            r_d1z   <= '0;
            r_d1o   <= '0;
        end else begin
            if (flush) begin
                r_v1 <= 1'b0;
            end else if (w_ld1) begin
                r_v1 <= w_acc;
            end
            if (w_acc) begin
                r_last1 <= in_last;
                r_d0z   <= w_d0z;
                r_d0o   <= w_d0o;
                r_d1z   <= w_d1z;
                r_d1o   <= w_d1o;
            end
        end
    end

    // Stage 2: register all branch sums and the frame-end tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_bm    <= '0;
        end else begin
            if (flush) begin
                r_v2 <= 1'b0;
            end else if (w_ld2) begin
                r_v2 <= r_v1;
            end
            if (w_load2) begin
                r_last2 <= r_last1;
                r_bm    <= w_bm;
            end
        end
    end

    // Count output transfers; a frame end restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            if (r_last2) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign out_valid = r_v2;
    assign out_last  = r_last2;
    assign bm        = r_bm;
    assign sym_cnt   = r_cnt;

endmodule

// File: tb/tb_bmu_soft_pipe.sv
// Directed bench for bmu_soft_pipe (soft SW=3 and hard SW=1 instances).
module tb_bmu_soft_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic        in_last;
    logic [1:0]  erase;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] bm;
    logic        out_last;
    logic [15:0] sym_cnt;

    logic        hv;
    logic        hrdy;
    logic        hr0;
    logic        hr1;
    logic        hlast;
    logic [1:0]  herase;
    logic        hov;
    logic        hor;
    logic [15:0] hbm;
    logic        hol;
    logic [15:0] hcnt;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    bmu_soft_pipe #(.SW(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .r0(r0), .r1(r1), .in_last(in_last), .erase(erase),
        .out_valid(out_valid), .out_ready(out_ready),
        .bm(bm), .out_last(out_last), .sym_cnt(sym_cnt)
    );

    bmu_soft_pipe #(.SW(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(hv), .in_ready(hrdy),
        .r0(hr0), .r1(hr1), .in_last(hlast), .erase(herase),
        .out_valid(hov), .out_ready(hor),
        .bm(hbm), .out_last(hol), .sym_cnt(hcnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [2:0]  t3r0 [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2};
        logic [2:0]  t3r1 [5] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3};
        logic [15:0] hexp [4] = '{16'h5528, 16'h8255, 16'h2855, 16'h5582};
        logic [1:0]  hp;
        logic [31:0] exp6;
        int idx;
        int oidx;
        logic acc;
        logic xf;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; r0 = '0; r1 = '0;
        in_last = 1'b0; erase = 2'b00; out_ready = 1'b1;
        hv = 1'b0; hr0 = 1'b0; hr1 = 1'b0; hlast = 1'b0;
        herase = 2'b00; hor = 1'b1;

        // reset state
        #3;
        chk("rst_ov", {31'd0, out_valid}, 0);
        chk("rst_ir", {31'd0, in_ready}, 0);
        chk("rst_bm", bm, 0);
        chk("rst_cnt", {16'd0, sym_cnt}, 0);
        chk("rst_ol", {31'd0, out_last}, 0);
        rst_n = 1'b1;
        tick();
        chk("rst_ir_up", {31'd0, in_ready}, 1);

        // test 1: r=(0,7)
        in_valid = 1'b1; r0 = 3'd0; r1 = 3'd7;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_lat1", {31'd0, out_valid}, 0);
        tick();
        chk("t1_ov", {31'd0, out_valid}, 1);
        chk("t1_bm", bm, 32'hE00E7777);
        tick();
        chk("t1_ov_off", {31'd0, out_valid}, 0);
        chk("t1_cnt", {16'd0, sym_cnt}, 1);

        // test 6: erase r1
`ifdef BMU_ERASURE_EN
        exp6 = 32'h70070770;
`else
        exp6 = 32'hE00E7777;
`endif
        in_valid = 1'b1; erase = 2'b10;
        tick();
        in_valid = 1'b0; erase = 2'b00;
        tick();
        chk("t6_ov", {31'd0, out_valid}, 1);
        chk("t6_bm", bm, exp6);
        tick();

        // test 2: hard decision, four symbols back to back
        for (int i = 0; i < 7; i++) begin
            hp = 2'(i);
            hv = (i < 4);
            hr0 = hp[1];
            hr1 = hp[0];
            #1;
            if (i >= 2 && i <= 5) begin
                chk("t2_ov", {31'd0, hov}, 1);
                chk("t2_bm", {16'd0, hbm}, {16'd0, hexp[i-2]});
            end
            if (i == 6) chk("t2_ov_off", {31'd0, hov}, 0);
            tick();
        end
        hv = 1'b0;

        // test 3: five symbols, stall cycles 3..5
        do_reset();
        idx = 0;
        oidx = 0;
        for (int c = 0; c < 30 && oidx < 5; c++) begin
            in_valid = (idx < 5);
            r0 = (idx < 5) ? t3r0[idx] : 3'd0;
            r1 = (idx < 5) ? t3r1[idx] : 3'd0;
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (c == 3 || c == 4) chk("t3_stall_ir", {31'd0, in_ready}, 0);
            if (c == 4) chk("t3_hold", {28'd0, bm[3:0]}, 2);
            acc = in_valid && in_ready;
            xf = out_valid && out_ready;
            if (xf) begin
                chk("t3_order", {28'd0, bm[3:0]}, 32'(oidx + 1));
                oidx++;
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t3_nout", 32'(oidx), 5);
        chk("t3_nin", 32'(idx), 5);
        chk("t3_cnt", {16'd0, sym_cnt}, 5);
        chk("t3_nodup", {31'd0, out_valid}, 0);

        // test 4: in_last on third symbol
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 5);
            r0 = 3'd0;
            r1 = 3'(i);
            in_last = (i == 2);
            #1;
            if (i >= 2 && i <= 6) begin
                chk("t4_ol", {31'd0, out_last}, {31'd0, i == 4});
                chk("t4_bm", {28'd0, bm[3:0]}, 32'(i - 2));
            end
            if (i == 4) chk("t4_cnt_pre", {16'd0, sym_cnt}, 2);
            if (i == 5) chk("t4_cnt_clr", {16'd0, sym_cnt}, 0);
            if (i == 7) chk("t4_cnt_end", {16'd0, sym_cnt}, 2);
            tick();
        end
        in_valid = 1'b0;
        in_last = 1'b0;

        // test 5a: async reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; r0 = 3'd1; r1 = 3'd1;
        tick();
        tick();
        in_valid = 1'b0;
        #1;
        chk("t5_full_ov", {31'd0, out_valid}, 1);
        chk("t5_full_ir", {31'd0, in_ready}, 0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ov", {31'd0, out_valid}, 0);
        chk("t5_rst_cnt", {16'd0, sym_cnt}, 0);
        chk("t5_rst_ol", {31'd0, out_last}, 0);
        rst_n = 1'b1;
        #1;
        chk("t5_rel_ir", {31'd0, in_ready}, 0);
        tick();
        chk("t5_up_ir", {31'd0, in_ready}, 1);
        chk("t5_up_ov", {31'd0, out_valid}, 0);

        // test 5b: flush with output stage full
        out_ready = 1'b1;
        in_valid = 1'b1; r0 = 3'd0; r1 = 3'd3;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("t5_pre_cnt", {16'd0, sym_cnt}, 1);
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_pre_ov", {31'd0, out_valid}, 1);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("t5_fl_ir", {31'd0, in_ready}, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_fl_ov", {31'd0, out_valid}, 0);
        chk("t5_fl_cnt", {16'd0, sym_cnt}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
